// File: rtl/idu_stage_if.sv
// Decode-stage bus: the IFU-side request (in_*) and the EXU-side decoded
// bundle (out_*).
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. The producer holds valid and its payload steady until that
// edge. The consumer may raise or lower ready at any time.
//
// Modports:
//   slave  - the decode stage. It consumes in_* and produces out_*.
//   master - the environment around the stage (IFU/EXU or a bench).
interface idu_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [WIDTH-1:0] in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [4:0]       out_rd_addr;
  logic [4:0]       out_rs1_addr;
  logic [4:0]       out_rs2_addr;
  logic [WIDTH-1:0] out_imm;
  logic [3:0]       out_alu_op;
  logic             out_alu_left_sel;
  logic             out_alu_right_sel;
  logic             out_rd_we;
  logic [1:0]       out_rd_input_sel;
  logic             out_mem_re;
  logic             out_mem_we;
  logic [2:0]       out_mem_op;
  logic             out_is_branch;
  logic             out_is_jal;
  logic             out_is_jalr;
  logic [2:0]       out_br_cond;
  logic             out_csr_we;
  logic             out_csr_sel;
  logic             out_is_ecall;
  logic             out_is_mret;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd_addr, out_rs1_addr, out_rs2_addr,
           out_imm, out_alu_op, out_alu_left_sel, out_alu_right_sel, out_rd_we,
           out_rd_input_sel, out_mem_re, out_mem_we, out_mem_op, out_is_branch,
           out_is_jal, out_is_jalr, out_br_cond, out_csr_we, out_csr_sel,
           out_is_ecall, out_is_mret, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd_addr, out_rs1_addr, out_rs2_addr,
           out_imm, out_alu_op, out_alu_left_sel, out_alu_right_sel, out_rd_we,
           out_rd_input_sel, out_mem_re, out_mem_we, out_mem_op, out_is_branch,
           out_is_jal, out_is_jalr, out_br_cond, out_csr_we, out_csr_sel,
           out_is_ecall, out_is_mret, out_illegal
  );
endinterface

// File: rtl/idu_stage.sv
// RV32I+Zicsr decode stage. It decodes one instruction per cycle and
// registers the resulting control bundle, giving a latency of one cycle.
// Branches are not resolved here: the type and condition are passed on so
// that the EXU can evaluate them.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   flush - drops the held bundles and the instruction presented this cycle
//   bus   - idu_stage_if.slave: in_* request side, out_* decoded bundle
//
// Parameters:
//   WIDTH - PC/immediate width (32 or 64)
//   SKID  - 0: one output register; 1: output register plus a one-entry skid
//           buffer, so that in_ready does not depend on out_ready
//
// ALU opcodes: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra,
//              8 or, 9 and, 10 pass the right operand (lui)
module idu_stage #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  idu_stage_if.slave   bus
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                         ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                         ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                         ALU_AND = 4'd9, ALU_PASS = 4'd10;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [4:0]       rd_addr;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [WIDTH-1:0] imm;
    logic [3:0]       alu_op;
    logic             alu_left_sel;
    logic             alu_right_sel;
    logic             rd_we;
    logic [1:0]       rd_input_sel;
    logic             mem_re;
    logic             mem_we;
    logic [2:0]       mem_op;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic [2:0]       br_cond;
    logic             csr_we;
    logic             csr_sel;
    logic             is_ecall;
    logic             is_mret;
    logic             illegal;
  } bundle_t;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        shamt_ok;
  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  // On RV32, shamt[5] (inst[25]) must be zero. On RV64 it is part of shamt.
  assign shamt_ok = (WIDTH == 64) || !inst[25];

  // Shared by OP and OP-IMM. alt picks sub over add and sra over srl.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  bundle_t     dec;
  logic [31:0] imm32;
  logic        legal;

  always_comb begin
    dec          = '0;
    imm32        = '0;
    legal        = 1'b1;
    dec.pc       = bus.in_pc;
    dec.rd_addr  = inst[11:7];
    dec.rs1_addr = inst[19:15];
    dec.rs2_addr = inst[24:20];
    case (opcode)
      7'b0110111: begin // lui
        imm32 = {inst[31:12], 12'b0};
        dec.alu_op = ALU_PASS; dec.alu_left_sel = 1'b1; dec.alu_right_sel = 1'b1;
        dec.rd_we = 1'b1;
      end
      7'b0010111: begin // auipc
        imm32 = {inst[31:12], 12'b0};
        dec.alu_left_sel = 1'b1; dec.alu_right_sel = 1'b1; dec.rd_we = 1'b1;
      end
      7'b1101111: begin // jal
        imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        dec.alu_left_sel = 1'b1; dec.rd_we = 1'b1; dec.is_jal = 1'b1;
      end
      7'b1100111: begin // jalr
        imm32 = {{20{inst[31]}}, inst[31:20]};
        dec.rd_we = 1'b1; dec.is_jalr = 1'b1;
        legal = (f3 == 3'b000);
      end
      7'b1100011: begin // branch
        imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        dec.alu_op = ALU_SUB; dec.is_branch = 1'b1; dec.br_cond = f3;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      7'b0000011: begin // load
        imm32 = {{20{inst[31]}}, inst[31:20]};
        dec.alu_right_sel = 1'b1; dec.rd_we = 1'b1; dec.rd_input_sel = 2'b01;
        dec.mem_re = 1'b1; dec.mem_op = f3;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      7'b0100011: begin // store
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        dec.alu_right_sel = 1'b1; dec.mem_we = 1'b1; dec.mem_op = f3;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end
      7'b0010011: begin // op-imm
        imm32 = {{20{inst[31]}}, inst[31:20]};
        dec.alu_right_sel = 1'b1; dec.rd_we = 1'b1;
        dec.alu_op = alu_from_f3(f3, (f3 == 3'b101) && inst[30]);
        if (f3 == 3'b001)
          legal = (inst[31:26] == 6'b000000) && shamt_ok;
        else if (f3 == 3'b101)
          legal = ((inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000)) && shamt_ok;
      end
      7'b0110011: begin // op
        dec.rd_we  = 1'b1;
        dec.alu_op = alu_from_f3(f3, f7[5]);
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      7'b1110011: begin // system
        imm32 = {{20{inst[31]}}, inst[31:20]};
        if (inst == 32'h0000_0073)      dec.is_ecall = 1'b1;
        else if (inst == 32'h3020_0073) dec.is_mret  = 1'b1;
        else if ((f3 == 3'b001) || (f3 == 3'b010)) begin
          dec.csr_we = 1'b1; dec.csr_sel = f3[1];
          dec.rd_we = 1'b1; dec.rd_input_sel = 2'b10;
        end else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    dec.imm   = WIDTH'($signed(imm32));
    dec.rd_we = dec.rd_we && (dec.rd_addr != 5'd0);
    if (!legal) begin
      // Only the identity fields survive. Everything with a side effect is
      // cleared, and the EXU raises the trap from the illegal flag.
      dec          = '0;
      dec.pc       = bus.in_pc;
      dec.rd_addr  = inst[11:7];
      dec.rs1_addr = inst[19:15];
      dec.rs2_addr = inst[24:20];
      dec.illegal  = 1'b1;
    end
  end

  bundle_t out_q, skid_q;
  logic    out_valid, skid_valid, in_ready, accept;

  // With SKID=1, ready depends only on registered state. With SKID=0 it
  // follows out_ready combinationally.
  assign in_ready = rst_n && ((SKID != 0) ? !skid_valid : (!out_valid || bus.out_ready));
  assign accept   = bus.in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || bus.out_ready) begin
      // The output slot is free this edge. The older skid entry goes first.
      // in_ready is low while the skid buffer is full, so nothing is
      // accepted on the same edge.
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = out_valid;
  assign bus.out_pc            = out_q.pc;
  assign bus.out_rd_addr       = out_q.rd_addr;
  assign bus.out_rs1_addr      = out_q.rs1_addr;
  assign bus.out_rs2_addr      = out_q.rs2_addr;
  assign bus.out_imm           = out_q.imm;
  assign bus.out_alu_op        = out_q.alu_op;
  assign bus.out_alu_left_sel  = out_q.alu_left_sel;
  assign bus.out_alu_right_sel = out_q.alu_right_sel;
  assign bus.out_rd_we         = out_q.rd_we;
  assign bus.out_rd_input_sel  = out_q.rd_input_sel;
  assign bus.out_mem_re        = out_q.mem_re;
  assign bus.out_mem_we        = out_q.mem_we;
  assign bus.out_mem_op        = out_q.mem_op;
  assign bus.out_is_branch     = out_q.is_branch;
  assign bus.out_is_jal        = out_q.is_jal;
  assign bus.out_is_jalr       = out_q.is_jalr;
  assign bus.out_br_cond       = out_q.br_cond;
  assign bus.out_csr_we        = out_q.csr_we;
  assign bus.out_csr_sel       = out_q.csr_sel;
  assign bus.out_is_ecall      = out_q.is_ecall;
  assign bus.out_is_mret       = out_q.is_mret;
  assign bus.out_illegal       = out_q.illegal;
endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage. Instance a is WIDTH=32 with the skid buffer.
// Instance b is WIDTH=64 without the skid buffer.
module tb_idu_stage;
  logic clk;
  logic rst_n;
  logic flush_a, flush_b;
  int   checks = 0;
  int   errors = 0;

  idu_stage_if #(.WIDTH(32)) bus_a ();
  idu_stage_if #(.WIDTH(64)) bus_b ();

  idu_stage #(.WIDTH(32), .SKID(1)) u_a (.clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a.slave));
  idu_stage #(.WIDTH(64), .SKID(0)) u_b (.clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b.slave));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_a(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    bus_a.in_valid = v;
    bus_a.in_inst  = inst;
    bus_a.in_pc    = pc;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] inst, input logic [63:0] pc);
    bus_b.in_valid = v;
    bus_b.in_inst  = inst;
    bus_b.in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    drive_a(1'b0, 32'h0, 32'h0);
    drive_b(1'b0, 32'h0, 64'h0);
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;
    #2;
    chk("a_ready_in_reset", {63'b0, bus_a.in_ready}, 64'd0);
    tick();
    chk("a_valid_reset", {63'b0, bus_a.out_valid}, 64'd0);
    chk("a_pc_reset", {32'b0, bus_a.out_pc}, 64'd0);
    chk("a_imm_reset", {32'b0, bus_a.out_imm}, 64'd0);
    chk("b_valid_reset", {63'b0, bus_b.out_valid}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("a_ready_after_reset", {63'b0, bus_a.in_ready}, 64'd1);

    // addi x1,x0,5
    bus_a.out_ready = 1'b1;
    drive_a(1'b1, 32'h0050_0093, 32'h8000_0000);
    tick();
    chk("addi_valid", {63'b0, bus_a.out_valid}, 64'd1);
    chk("addi_rd", {59'b0, bus_a.out_rd_addr}, 64'd1);
    chk("addi_rd_we", {63'b0, bus_a.out_rd_we}, 64'd1);
    chk("addi_imm", {32'b0, bus_a.out_imm}, 64'd5);
    chk("addi_right_sel", {63'b0, bus_a.out_alu_right_sel}, 64'd1);
    chk("addi_pc", {32'b0, bus_a.out_pc}, 64'h8000_0000);
    chk("addi_alu_op", {60'b0, bus_a.out_alu_op}, 64'd0);

    // sw x1,12(x2)
    drive_a(1'b1, 32'h0011_2623, 32'h8000_0004);
    tick();
    chk("sw_mem_we", {63'b0, bus_a.out_mem_we}, 64'd1);
    chk("sw_mem_op", {61'b0, bus_a.out_mem_op}, 64'd2);
    chk("sw_imm", {32'b0, bus_a.out_imm}, 64'd12);
    chk("sw_rs1", {59'b0, bus_a.out_rs1_addr}, 64'd2);
    chk("sw_rs2", {59'b0, bus_a.out_rs2_addr}, 64'd1);
    chk("sw_rd_we", {63'b0, bus_a.out_rd_we}, 64'd0);

    // addi x0,x0,0: the write to x0 is suppressed
    drive_a(1'b1, 32'h0000_0013, 32'h8000_0008);
    tick();
    chk("nop_rd_we", {63'b0, bus_a.out_rd_we}, 64'd0);
    chk("nop_illegal", {63'b0, bus_a.out_illegal}, 64'd0);

    // all-zero word is illegal
    drive_a(1'b1, 32'h0000_0000, 32'h8000_000C);
    tick();
    chk("zero_illegal", {63'b0, bus_a.out_illegal}, 64'd1);
    chk("zero_rd_we", {63'b0, bus_a.out_rd_we}, 64'd0);
    chk("zero_valid", {63'b0, bus_a.out_valid}, 64'd1);

    // mret
    drive_a(1'b1, 32'h3020_0073, 32'h8000_0010);
    tick();
    chk("mret_flag", {63'b0, bus_a.out_is_mret}, 64'd1);
    chk("mret_rd_we", {63'b0, bus_a.out_rd_we}, 64'd0);
    chk("mret_illegal", {63'b0, bus_a.out_illegal}, 64'd0);

    // slli x1,x1,32 is illegal on RV32
    drive_a(1'b1, 32'h0200_9093, 32'h8000_0014);
    tick();
    chk("slli32_illegal", {63'b0, bus_a.out_illegal}, 64'd1);

    // srai x1,x1,3
    drive_a(1'b1, 32'h4030_D093, 32'h8000_0018);
    tick();
    chk("srai_alu_op", {60'b0, bus_a.out_alu_op}, 64'd7);
    chk("srai_illegal", {63'b0, bus_a.out_illegal}, 64'd0);

    // sub x3,x1,x2
    drive_a(1'b1, 32'h4020_81B3, 32'h8000_001C);
    tick();
    chk("sub_alu_op", {60'b0, bus_a.out_alu_op}, 64'd1);
    chk("sub_imm", {32'b0, bus_a.out_imm}, 64'd0);
    chk("sub_right_sel", {63'b0, bus_a.out_alu_right_sel}, 64'd0);
    chk("sub_rd", {59'b0, bus_a.out_rd_addr}, 64'd3);

    // lui x5,0x12345
    drive_a(1'b1, 32'h1234_52B7, 32'h8000_0020);
    tick();
    chk("lui_imm", {32'b0, bus_a.out_imm}, 64'h1234_5000);
    chk("lui_alu_op", {60'b0, bus_a.out_alu_op}, 64'd10);
    chk("lui_left_sel", {63'b0, bus_a.out_alu_left_sel}, 64'd1);
    chk("lui_rd", {59'b0, bus_a.out_rd_addr}, 64'd5);

    drive_a(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain_valid", {63'b0, bus_a.out_valid}, 64'd0);

    // skid: three back-to-back issues under backpressure
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 32'h0010_0093, 32'h0000_0100);
    tick();
    chk("skid1_valid", {63'b0, bus_a.out_valid}, 64'd1);
    chk("skid1_ready", {63'b0, bus_a.in_ready}, 64'd1);
    drive_a(1'b1, 32'h0020_0113, 32'h0000_0104);
    tick();
    chk("skid2_ready", {63'b0, bus_a.in_ready}, 64'd0);
    chk("skid2_pc_hold", {32'b0, bus_a.out_pc}, 64'h100);
    drive_a(1'b1, 32'h0030_0193, 32'h0000_0108);
    tick();
    chk("skid3_ready", {63'b0, bus_a.in_ready}, 64'd0);
    chk("skid3_pc_hold", {32'b0, bus_a.out_pc}, 64'h100);
    chk("skid3_rd_hold", {59'b0, bus_a.out_rd_addr}, 64'd1);
    bus_a.out_ready = 1'b1;
    tick();
    chk("skid_out2_pc", {32'b0, bus_a.out_pc}, 64'h104);
    chk("skid_out2_rd", {59'b0, bus_a.out_rd_addr}, 64'd2);
    chk("skid_out2_valid", {63'b0, bus_a.out_valid}, 64'd1);
    chk("skid_out2_ready", {63'b0, bus_a.in_ready}, 64'd1);
    tick();
    chk("skid_out3_pc", {32'b0, bus_a.out_pc}, 64'h108);
    chk("skid_out3_valid", {63'b0, bus_a.out_valid}, 64'd1);
    drive_a(1'b0, 32'h0, 32'h0);
    tick();
    chk("skid_drain_valid", {63'b0, bus_a.out_valid}, 64'd0);

    // flush with two held and a new instruction presented
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 32'h0010_0093, 32'h0000_0200);
    tick();
    drive_a(1'b1, 32'h0020_0113, 32'h0000_0204);
    tick();
    chk("flush_pre_ready", {63'b0, bus_a.in_ready}, 64'd0);
    drive_a(1'b1, 32'h0030_0193, 32'h0000_0208);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    drive_a(1'b0, 32'h0, 32'h0);
    chk("flush_valid", {63'b0, bus_a.out_valid}, 64'd0);
    chk("flush_ready", {63'b0, bus_a.in_ready}, 64'd1);
    bus_a.out_ready = 1'b1;
    tick();
    chk("flush_nothing_out", {63'b0, bus_a.out_valid}, 64'd0);

    // flush beats an acceptance the stage is ready for
    drive_a(1'b1, 32'h0010_0093, 32'h0000_020C);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    chk("flush_drop_valid", {63'b0, bus_a.out_valid}, 64'd0);
    drive_a(1'b1, 32'h0010_0093, 32'h0000_0210);
    tick();
    chk("post_flush_valid", {63'b0, bus_a.out_valid}, 64'd1);
    chk("post_flush_pc", {32'b0, bus_a.out_pc}, 64'h210);
    drive_a(1'b0, 32'h0, 32'h0);
    tick();

    // WIDTH=64, SKID=0: beq x0,x0,-4 under backpressure
    drive_b(1'b1, 32'hFE00_0EE3, 64'h1000);
    tick();
    drive_b(1'b0, 32'h0, 64'h0);
    chk("beq_valid", {63'b0, bus_b.out_valid}, 64'd1);
    chk("beq_is_branch", {63'b0, bus_b.out_is_branch}, 64'd1);
    chk("beq_br_cond", {61'b0, bus_b.out_br_cond}, 64'd0);
    chk("beq_imm", bus_b.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_rd_we", {63'b0, bus_b.out_rd_we}, 64'd0);
    chk("b_ready_stall", {63'b0, bus_b.in_ready}, 64'd0);
    bus_b.out_ready = 1'b1;
    #1;
    chk("b_ready_comb", {63'b0, bus_b.in_ready}, 64'd1);

    // lui x1,0x80000 sign-extends to 64 bits
    drive_b(1'b1, 32'h8000_00B7, 64'h1004);
    tick();
    chk("lui64_imm", bus_b.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_pc", bus_b.out_pc, 64'h1004);

    // slli x1,x1,32 is legal on RV64
    drive_b(1'b1, 32'h0200_9093, 64'h1008);
    tick();
    chk("slli64_illegal", {63'b0, bus_b.out_illegal}, 64'd0);
    chk("slli64_alu_op", {60'b0, bus_b.out_alu_op}, 64'd2);
    drive_b(1'b0, 32'h0, 64'h0);
    tick();
    chk("b_drain_valid", {63'b0, bus_b.out_valid}, 64'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
